// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU arbiter slice. It holds the
//                4-bit ALU control codes and the arbiter FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // ALU control codes
    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_SLT  = 4'b0111;
    localparam logic [3:0] c_ALU_SLTU = 4'b1000;
    localparam logic [3:0] c_ALU_SLL  = 4'b1001;
    localparam logic [3:0] c_ALU_SRA  = 4'b1010;
    localparam logic [3:0] c_ALU_SRL  = 4'b1011;
    localparam logic [3:0] c_ALU_XOR  = 4'b1101;

    // Arbiter FSM state encoding
    localparam int         c_ST_W    = 2;
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
// ============================================================================
//  Module      : alu_arbiter_alu
//  Description : Purely combinational 32-bit ALU. Shift amount is taken from
//                b[10:6]. Unknown control codes yield result 0 (zero = 1).
//  Ports       : i_ctrl   - 4-bit ALU control code
//                i_a      - operand A
//                i_b      - operand B (also carries shift amount)
//                o_result - ALU result
//                o_zero   - high when o_result is all zeros
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [3:0]  i_ctrl,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result,
    output logic        o_zero
);

    logic [4:0]  w_shamt;
    logic [31:0] w_result;

    assign w_shamt = i_b[10:6];

    always_comb begin
        w_result = 32'd0;
        case (i_ctrl)
            c_ALU_AND:  w_result = i_a & i_b;
            c_ALU_OR:   w_result = i_a | i_b;
            c_ALU_ADD:  w_result = i_a + i_b;
            c_ALU_SUB:  w_result = i_a - i_b;
            c_ALU_SLT:  w_result = {31'd0, ($signed(i_a) < $signed(i_b))};
            c_ALU_SLTU: w_result = {31'd0, (i_a < i_b)};
            c_ALU_SLL:  w_result = i_a << w_shamt;
            c_ALU_SRA:  w_result = 32'($signed(i_a) >>> w_shamt);
            c_ALU_SRL:  w_result = i_a >> w_shamt;
            c_ALU_XOR:  w_result = i_a ^ i_b;
            default:    w_result = 32'd0;
        endcase
    end

    assign o_result = w_result;
    assign o_zero   = (w_result == 32'd0);

endmodule : alu_arbiter_alu

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module      : alu_arbiter
//  Description : Two-requester round-robin front end for a single shared ALU.
//                One operation is in flight at a time: IDLE grants and
//                latches, EXEC computes and registers, RESP holds the result
//                until the consumer takes it.
//  Ports       : i_clk, i_rst_n                 - clock, async active-low reset
//                i_reqN_valid / o_reqN_ready    - requester N handshake
//                i_reqN_ctrl/_a/_b/_tag         - requester N operation
//                o_rsp_valid / i_rsp_ready      - response handshake
//                o_rsp_data/_zero/_id/_tag      - result, zero flag, origin
//                o_busy                         - high when not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [3:0]       i_req0_ctrl,
    input  logic [31:0]      i_req0_a,
    input  logic [31:0]      i_req0_b,
    input  logic [TAG_W-1:0] i_req0_tag,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [3:0]       i_req1_ctrl,
    input  logic [31:0]      i_req1_a,
    input  logic [31:0]      i_req1_b,
    input  logic [TAG_W-1:0] i_req1_tag,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      o_rsp_data,
    output logic             o_rsp_zero,
    output logic             o_rsp_id,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_busy
);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_next_state;

    // r_prio names the requester that wins a tie; 0 after reset.
    logic              r_prio;
    logic              w_any_valid;
    logic              w_grant_id;
    logic              w_accept;

    logic [3:0]        r_ctrl;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [TAG_W-1:0]  r_tag;
    logic              r_id;

    logic [31:0]       r_rsp_data;
    logic              r_rsp_zero;
    logic              r_rsp_id;
    logic [TAG_W-1:0]  r_rsp_tag;

    logic [31:0]       w_alu_result;
    logic              w_alu_zero;

    // ------------------------------------------------------------------
    // Arbitration: tie goes to r_prio, otherwise the lone valid requester.
    // ------------------------------------------------------------------
    assign w_any_valid = i_req0_valid | i_req1_valid;
    assign w_grant_id  = (i_req0_valid & i_req1_valid) ? r_prio : i_req1_valid;

    // The reset term keeps both readies low while reset is held, even
    // though the state register already reads IDLE.
    assign w_accept = (r_state == c_ST_IDLE) & w_any_valid & i_rst_n;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (w_any_valid) w_next_state = c_ST_EXEC;
            c_ST_EXEC: w_next_state = c_ST_RESP;
            c_ST_RESP: if (i_rsp_ready) w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_req0_ready = w_accept & ~w_grant_id;
        o_req1_ready = w_accept &  w_grant_id;
        o_busy       = (r_state != c_ST_IDLE);
        o_rsp_valid  = (r_state == c_ST_RESP);
    end

    // ------------------------------------------------------------------
    // Operand capture and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prio     <= 1'b0;
            r_ctrl     <= 4'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_tag      <= '0;
            r_id       <= 1'b0;
            r_rsp_data <= 32'd0;
            r_rsp_zero <= 1'b0;
            r_rsp_id   <= 1'b0;
            r_rsp_tag  <= '0;
        end else begin
            if (w_accept) begin
                r_prio <= ~w_grant_id;
                r_id   <= w_grant_id;
                r_ctrl <= w_grant_id ? i_req1_ctrl : i_req0_ctrl;
                r_a    <= w_grant_id ? i_req1_a    : i_req0_a;
                r_b    <= w_grant_id ? i_req1_b    : i_req0_b;
                r_tag  <= w_grant_id ? i_req1_tag  : i_req0_tag;
            end
            // Response fields only change on the EXEC->RESP transition, so
            // they stay frozen for the whole RESP stall.
            if (r_state == c_ST_EXEC) begin
                r_rsp_data <= w_alu_result;
                r_rsp_zero <= w_alu_zero;
                r_rsp_id   <= r_id;
                r_rsp_tag  <= r_tag;
            end
        end
    end

    assign o_rsp_data = r_rsp_data;
    assign o_rsp_zero = r_rsp_zero;
    assign o_rsp_id   = r_rsp_id;
    assign o_rsp_tag  = r_rsp_tag;

    alu_arbiter_alu u_alu (
        .i_ctrl   (r_ctrl),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

endmodule : alu_arbiter

`default_nettype wire
